// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 16-bit address bus.
// Latches a bus request, runs a fixed-timing access cycle on an async SRAM
// (SETUP, WAIT_CYCLES x ACCESS, DONE) and pulses o_ready on completion.
// Writes at or below ROM_TOP are rejected: no write strobe, o_err pulses with o_ready.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_addr/i_req/i_we/i_data : request, sampled when accepted (IDLE or DONE)
//   i_noe                    : active-low output enable for o_data
//   o_data                   : read-data register, high-Z when i_noe = 1
//   o_ready, o_err           : one-cycle completion / rejected-write pulses
//   o_busy                   : high whenever not IDLE
//   o_mem_addr, o_mem_wdata, o_mem_drive, i_mem_rdata : SRAM address/data
//   o_mem_ce_n, o_mem_oe_n, o_mem_we_n                : active-low SRAM strobes
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] ROM_TOP     = 16'h7FFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [7:0]  i_data,
  input  logic        i_noe,
  output logic [7:0]  o_data,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_drive,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_mem_ce_n,
  output logic        o_mem_oe_n,
  output logic        o_mem_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        we_q;
  logic        rom_q;
  logic        accept;
  logic        last;

  // New requests are only taken in IDLE or on the exiting edge of DONE.
  assign accept = i_req && ((state == IDLE) || (state == DONE));
  assign last   = (state == ACCESS) && (cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_busy      = 1'b1;
    o_ready     = 1'b0;
    o_err       = 1'b0;
    o_mem_ce_n  = 1'b1;
    o_mem_oe_n  = 1'b1;
    o_mem_we_n  = 1'b1;
    o_mem_drive = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_req) state_nxt = SETUP;
      end
      SETUP: begin
        o_mem_ce_n  = 1'b0;
        o_mem_drive = we_q;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        o_mem_ce_n  = 1'b0;
        o_mem_drive = we_q;
        o_mem_oe_n  = we_q;
        // A rejected ROM write keeps only chip-enable asserted.
        o_mem_we_n  = !(we_q && !rom_q);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        o_ready   = 1'b1;
        o_err     = we_q && rom_q;
        state_nxt = i_req ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rom_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= i_addr;
        wdata_q <= i_data;
        we_q    <= i_we;
        rom_q   <= (i_addr <= ROM_TOP);
      end
      if (state == SETUP)       cnt <= '0;
      else if (state == ACCESS) cnt <= cnt + 4'd1;
      if (last && !we_q) rdata_q <= i_mem_rdata;
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_data      = i_noe ? 8'bzzzz_zzzz : rdata_q;

endmodule
